systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Upstream stage of the SIZE x SIZE systolic MAC array.
- Holds operand matrices A (rows feed a_in) and B (columns feed b_in) in internal register buffers.
- On start, drives the array's a_in/b_in with the diagonal-wavefront skew: row i and column j are delayed i and j cycles respectively.
- Generates the array's load_en/mult_en/acc_en controls and signals completion with a busy/done handshake.

Parameters:
SIZE, 4, array dimension; matrices are SIZE x SIZE, 8-bit elements.
IDXW, $clog2(SIZE), width of the row/column index on the write port.

Ports:
clk  input  1  single clock; all logic rising-edge.
reset  input  1  synchronous, active-high reset.
wr_en  input  1  buffer write strobe.
wr_sel  input  1  0 = write A, 1 = write B.
wr_row  input  IDXW  element row index.
wr_col  input  IDXW  element column index.
wr_data  input  8  element value.
start  input  1  begin one multiply pass.
busy  output  1  pass in progress.
done  output  1  one-cycle completion pulse.
load_en  output  1  to array: one-cycle accumulator clear/load.
mult_en  output  1  to array: multiply enable.
acc_en  output  1  to array: accumulate enable.
a_feed  output  8 x [0:SIZE-1]  to array a_in[i].
b_feed  output  8 x [0:SIZE-1]  to array b_in[j].

Behaviour:
- Reset, synchronous, active-high:
  - State IDLE; both buffers cleared to 0.
  - All outputs 0: busy, done, load_en, mult_en, acc_en, and all a_feed/b_feed lanes.
  - Reset mid-pass aborts: outputs 0 on the next cycle, done is not pulsed.
- All outputs are registered.
- Writes:
  - Accepted only when busy=0. The write commits at the clock edge.
  - wr_en while busy=1 is ignored and the buffers are unchanged.
  - Indices >= SIZE are ignored.
- FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> IDLE. Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- IDLE: outputs 0. start=1 moves to CLEAR.
- CLEAR (cycle 1):
  - busy=1, load_en=1, mult_en=acc_en=0, feeds 0.
  - Next state: STREAM with t=0.
- STREAM (cycles 2 .. 2SIZE; t = 0 .. 2SIZE-2):
  - busy=1, mult_en=acc_en=1, load_en=0.
  - a_feed[i] = A[i][t-i] if 0 <= t-i < SIZE, else 0.
  - b_feed[j] = B[t-j][j] if 0 <= t-j < SIZE, else 0.
  - t is a counter that is not incremented past 2SIZE-2; then go to DRAIN.
- DRAIN (SIZE cycles):
  - busy=1, mult_en=acc_en=1, feeds 0.
  - Lets the last wavefront reach PE[SIZE-1][SIZE-1].
- End of pass (cycle 3SIZE+1): return to IDLE with busy=0 and done=1 for one cycle.
- Timing: busy is high for exactly 3SIZE cycles. For SIZE=4: busy in cycles 1..12, done in cycle 13.
- Simultaneous events:
  - start while busy=1: ignored, no queuing.
  - start in the done cycle: accepted, because the state is IDLE. CLEAR follows in the next cycle.
  - wr_en and start in the same IDLE cycle: the write commits first, and the pass uses the new value.
- Buffers are not modified by a pass, so repeated starts reuse the same operands.

Optional Feature:
- Macro: FEEDER_CYCLE_CNT_EN.
- Defined:
  - Adds output cycle_cnt [15:0].
  - Cleared to 0 by reset and whenever a start is accepted.
  - Increments every cycle busy=1 and saturates at 16'hFFFF.
  - Holds its value after done; reads 3SIZE after a complete pass.
- Undefined: no port, no counter logic; the remaining behaviour is identical.

Test Plan:
- Skew pattern, SIZE=4:
  - Stimulus: load A[i][k] = 16i+k+1 and B[k][j] = 16k+j+0x81, pulse start.
  - a_feed[2]: 0 in STREAM t=0,1; 0x21 at t=2; 0x24 at t=5; 0 at t=6.
  - b_feed[3]: 0x81+3 = 0x84 at t=3.
  - All feeds are 0 during CLEAR and DRAIN.
- Handshake timing:
  - Stimulus: start in cycle 0.
  - load_en=1 only in cycle 1; busy=1 in cycles 1..12; mult_en=acc_en=1 in cycles 2..12; done=1 only in cycle 13.
- Ignored inputs while busy:
  - Stimulus: at cycle 5, assert start and wr_en (A[0][0] <- 0xFF).
  - No restart; done still occurs at cycle 13.
  - A second pass still streams the original A[0][0] = 0x01.
- Reset mid-STREAM:
  - Stimulus: reset in cycle 6.
  - Cycle 7: all outputs 0 and no done follows.
  - Buffers read back 0 on a new pass; a fresh start is accepted normally.
- Back-to-back passes:
  - Stimulus: start asserted in the done cycle (13).
  - load_en=1 in cycle 14; second done at cycle 26.
  - With the array attached and A = identity, array out = B after each pass.
- FEEDER_CYCLE_CNT_EN defined: cycle_cnt = 12 after done, and resets to 0 on the next accepted start.

Source files
------------

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand buffers and skewed wavefront feeder for a SIZE x SIZE systolic MAC array
// Optional cycle counter output enabled by defining FEEDER_CYCLE_CNT_EN.
module systolic_feeder #(
    parameter int SIZE = 4,
    parameter int IDXW = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [IDXW-1:0]       wr_row,
    input  logic [IDXW-1:0]       wr_col,
    input  logic [7:0]            wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  load_en,
    output logic                  mult_en,
    output logic                  acc_en,
`ifdef FEEDER_CYCLE_CNT_EN
    output logic [15:0]           cycle_cnt,
`endif
    output logic [SIZE-1:0][7:0]  a_feed,
    output logic [SIZE-1:0][7:0]  b_feed
);

    localparam int TW    = $clog2(2 * SIZE);
    localparam int TLAST = 2 * SIZE - 2;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN
    } state_t;

    state_t          state;
    logic [TW-1:0]   t_cnt;
    logic [TW-1:0]   d_cnt;
    logic [TW-1:0]   t_next;
    logic [7:0]      a_buf [SIZE][SIZE];
    logic [7:0]      b_buf [SIZE][SIZE];
    logic [SIZE-1:0][7:0] a_next;
    logic [SIZE-1:0][7:0] b_next;
    logic            wr_ok;

    assign wr_ok = wr_en && !busy && (int'(wr_row) < SIZE) && (int'(wr_col) < SIZE);

    // Feed values for the wavefront step that becomes visible after the next edge.
    always_comb begin
        int k;
        k      = 0;
        t_next = (state == STREAM) ? t_cnt + TW'(1) : '0;
        a_next = '0;
        b_next = '0;
        for (int i = 0; i < SIZE; i++) begin
            k = int'(t_next) - i;
            if (k >= 0 && k < SIZE) begin
                a_next[i] = a_buf[i][k];
                b_next[i] = b_buf[k][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            t_cnt   <= '0;
            d_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            load_en <= 1'b0;
            mult_en <= 1'b0;
            acc_en  <= 1'b0;
            a_feed  <= '0;
            b_feed  <= '0;
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    a_buf[r][c] <= 8'h00;
                    b_buf[r][c] <= 8'h00;
                end
            end
        end else begin
            if (wr_ok) begin
                if (wr_sel)
                    b_buf[wr_row][wr_col] <= wr_data;
                else
                    a_buf[wr_row][wr_col] <= wr_data;
            end
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        load_en <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= STREAM;
                    t_cnt   <= '0;
                    load_en <= 1'b0;
                    mult_en <= 1'b1;
                    acc_en  <= 1'b1;
                    a_feed  <= a_next;
                    b_feed  <= b_next;
                end
                STREAM: begin
                    if (t_cnt == TW'(TLAST)) begin
                        state  <= DRAIN;
                        d_cnt  <= '0;
                        a_feed <= '0;
                        b_feed <= '0;
                    end else begin
                        t_cnt  <= t_next;
                        a_feed <= a_next;
                        b_feed <= b_next;
                    end
                end
                DRAIN: begin
                    if (d_cnt == TW'(SIZE - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        mult_en <= 1'b0;
                        acc_en  <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        d_cnt <= d_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FEEDER_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 16'h0000;
        end else if (state == IDLE && start) begin
            cycle_cnt <= 16'h0000;
        end else if (busy && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder (honours FEEDER_CYCLE_CNT_EN)
module tb_systolic_feeder;

    localparam int S     = 4;
    localparam int IW    = 2;
    localparam int EW    = 5 + 2 * S * 8;
    localparam int LASTN = 3 * S + 1;

    logic clk = 1'b0;
    logic reset, wr_en, wr_sel, start;
    logic [IW-1:0] wr_row, wr_col;
    logic [7:0] wr_data;
    logic busy, done, load_en, mult_en, acc_en;
    logic [S-1:0][7:0] a_feed, b_feed;
`ifdef FEEDER_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    systolic_feeder #(.SIZE(S), .IDXW(IW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .load_en(load_en), .mult_en(mult_en), .acc_en(acc_en),
`ifdef FEEDER_CYCLE_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .a_feed(a_feed), .b_feed(b_feed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] ma [S][S];
    logic [7:0] mb [S][S];
    logic [S-1:0][7:0] cap_a [0:LASTN];
    logic [S-1:0][7:0] cap_b [0:LASTN];
    logic [4:0]        cap_ctl [0:LASTN];

    typedef struct {
        int         t;
        int         lane;
        bit         is_b;
        logic [7:0] val;
    } skew_vec_t;

    typedef struct {
        int         cyc;
        logic [4:0] ctl;
    } hs_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] dut_vec();
        return {busy, done, load_en, mult_en, acc_en, a_feed, b_feed};
    endfunction

    // Expected outputs n cycles after the start cycle, straight from the pass timeline.
    function automatic logic [EW-1:0] model(input int n);
        logic b, d, l, m;
        logic [S-1:0][7:0] ea, eb;
        int t, k;
        b  = (n >= 1) && (n <= 3 * S);
        d  = (n == 3 * S + 1);
        l  = (n == 1);
        m  = (n >= 2) && (n <= 3 * S);
        ea = '0;
        eb = '0;
        if (n >= 2 && n <= 2 * S) begin
            t = n - 2;
            for (int i = 0; i < S; i++) begin
                k = t - i;
                if (k >= 0 && k < S) begin
                    ea[i] = ma[i][k];
                    eb[i] = mb[k][i];
                end
            end
        end
        return {b, d, l, m, m, ea, eb};
    endfunction

    task automatic wr(input bit sel, input int row, input int col, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = IW'(row);
        wr_col  = IW'(col);
        wr_data = 8'(data);
        tick();
        wr_en = 1'b0;
        if (sel) mb[row][col] = 8'(data);
        else     ma[row][col] = 8'(data);
    endtask

    // Start in the current cycle, check every cycle through done; optionally
    // inject start+write at cycle inj, or leave start high in the done cycle.
    task automatic do_pass(input bit chain, input int inj);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= LASTN; n++) begin
            check($sformatf("pass_cyc%0d", n), dut_vec(), model(n));
            cap_a[n]   = a_feed;
            cap_b[n]   = b_feed;
            cap_ctl[n] = {busy, done, load_en, mult_en, acc_en};
`ifdef FEEDER_CYCLE_CNT_EN
            if (n == 1)     check("cnt_cleared", EW'(cycle_cnt), EW'(0));
            if (n == LASTN) check("cnt_at_done", EW'(cycle_cnt), EW'(3 * S));
`endif
            if (n == inj) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = '0;
                wr_col  = '0;
                wr_data = 8'hFF;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (n == LASTN && chain) start = 1'b1;
            else if (n != LASTN) tick();
        end
        if (!chain) begin
            start = 1'b0;
            tick();
            check("idle_after_done", dut_vec(), '0);
`ifdef FEEDER_CYCLE_CNT_EN
            check("cnt_holds", EW'(cycle_cnt), EW'(3 * S));
`endif
        end
    endtask

    skew_vec_t skew_tbl [6];
    hs_vec_t   hs_tbl [6];

    initial begin
        logic [7:0] got;
        skew_tbl = '{
            '{0, 2, 1'b0, 8'h00}, '{1, 2, 1'b0, 8'h00}, '{2, 2, 1'b0, 8'h21},
            '{5, 2, 1'b0, 8'h24}, '{6, 2, 1'b0, 8'h00}, '{3, 3, 1'b1, 8'h84}
        };
        hs_tbl = '{
            '{1, 5'b10100}, '{2, 5'b10011}, '{7, 5'b10011},
            '{12, 5'b10011}, '{13, 5'b01000}, '{11, 5'b10011}
        };
        for (int i = 0; i < S; i++)
            for (int k = 0; k < S; k++) begin
                ma[i][k] = 8'h00;
                mb[i][k] = 8'h00;
            end

        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = 8'h00; start = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("reset_state", dut_vec(), '0);
`ifdef FEEDER_CYCLE_CNT_EN
        check("reset_cnt", EW'(cycle_cnt), EW'(0));
`endif

        // Skew pattern and handshake timing
        for (int i = 0; i < S; i++)
            for (int k = 0; k < S; k++) begin
                wr(1'b0, i, k, 16 * i + k + 1);
                wr(1'b1, i, k, 16 * i + k + 'h81);
            end
        do_pass(1'b0, -1);
        for (int v = 0; v < 6; v++) begin
            got = skew_tbl[v].is_b ? cap_b[skew_tbl[v].t + 2][skew_tbl[v].lane]
                                   : cap_a[skew_tbl[v].t + 2][skew_tbl[v].lane];
            check($sformatf("skew_vec%0d", v), EW'(got), EW'(skew_tbl[v].val));
        end
        for (int v = 0; v < 6; v++)
            check($sformatf("handshake_cyc%0d", hs_tbl[v].cyc),
                  EW'(cap_ctl[hs_tbl[v].cyc]), EW'(hs_tbl[v].ctl));

        // start and write while busy are ignored
        do_pass(1'b0, 5);
        do_pass(1'b0, -1);
        check("a00_kept", EW'(cap_a[2][0]), EW'(8'h01));

        // Back-to-back: start in the done cycle
        do_pass(1'b1, -1);
        do_pass(1'b0, -1);
        check("b2b_load_second", EW'(cap_ctl[1]), EW'(5'b10100));

        // Reset mid-STREAM at cycle 6
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 7; n <= 16; n++) begin
            check($sformatf("abort_cyc%0d", n), dut_vec(), '0);
            tick();
        end
        for (int i = 0; i < S; i++)
            for (int k = 0; k < S; k++) begin
                ma[i][k] = 8'h00;
                mb[i][k] = 8'h00;
            end
        do_pass(1'b0, -1);

        // Randomized operands; last write coincides with start
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 24; w++) begin
                wr($urandom_range(0, 1) == 1, $urandom_range(0, S - 1),
                   $urandom_range(0, S - 1), $urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) tick();
            end
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_row  = IW'($urandom_range(0, S - 1));
            wr_col  = IW'($urandom_range(0, S - 1));
            wr_data = 8'($urandom_range(0, 255));
            ma[wr_row][wr_col] = wr_data;
            do_pass(r[0], -1);
            if (r[0]) do_pass(1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
